// File: rtl/play_btn_pkg.sv
// Shared types and default timing for the play-button controller.
// Defaults assume a 50 MHz clock.
package play_btn_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  localparam int unsigned DEBOUNCE_CYC_DEF = CLK_HZ / 50;
  localparam int unsigned LONG_PRESS_CYC_DEF = CLK_HZ;
  localparam int unsigned REPEAT_CYC_DEF = CLK_HZ * 8;

  localparam int CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG_DONE
  } btn_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-sample debouncer.
// pressed_o follows the input once it has held a new level long enough.
module btn_debounce
  import play_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pressed_o
);

  localparam cnt_t DB_LAST = cnt_t'(DEBOUNCE_CYC - 1);

  logic sync1_q, sync2_q;
  logic pressed_q, pressed_d;
  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    pressed_d = pressed_q;
    if (sync2_q != pressed_q) begin
      if (cnt_q == DB_LAST) begin
        pressed_d = sync2_q;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pressed_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pressed_q <= pressed_d;
      cnt_q <= cnt_d;
    end
  end

  assign pressed_o = pressed_q;

endmodule

// File: rtl/play_button_ctrl.sv
// Play button: debounced press pulse, long-press repeat toggle, auto-replay.
// Repeat logic is compiled in only when PLAY_BTN_REPEAT_EN is defined.
module play_button_ctrl
  import play_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned LONG_PRESS_CYC = LONG_PRESS_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic btn,
  output logic play,
  output logic pressed,
  output logic repeat_on
);

  if (DEBOUNCE_CYC < 1 || LONG_PRESS_CYC < 2 || REPEAT_CYC < 2)
  begin : g_bad_cfg
    $error("play_button_ctrl: cycle parameters out of range");
  end

  btn_state_e state_q, state_d;
  logic prev_q;
  logic play_q, play_d;
  logic rise, fall;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk_i    (clk_50MHz),
    .rst_ni   (rst_n),
    .btn_i    (btn),
    .pressed_o(pressed)
  );

  assign rise = pressed & ~prev_q;
  assign fall = ~pressed & prev_q;

`ifdef PLAY_BTN_REPEAT_EN
  localparam cnt_t LONG_LAST = cnt_t'(LONG_PRESS_CYC - 1);
  localparam cnt_t REP_LAST = cnt_t'(REPEAT_CYC - 1);

  cnt_t hold_q, hold_d;
  cnt_t rep_q, rep_d;
  logic repeat_q, repeat_d;
  logic wrap;

  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    repeat_d = repeat_q;
    rep_d = '0;
    wrap = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HELD;
          hold_d = '0;
        end
      end
      HELD: begin
        if (fall) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + cnt_t'(1);
          if (hold_d == LONG_LAST) begin
            state_d = LONG_DONE;
            repeat_d = ~repeat_q;
          end
        end
      end
      LONG_DONE: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (repeat_q) begin
      if (rep_q == REP_LAST) begin
        wrap = 1'b1;
      end else begin
        rep_d = rep_q + cnt_t'(1);
      end
    end
    // A press restarts the replay period so the two never double up.
    if (rise || (repeat_d && !repeat_q)) rep_d = '0;
    play_d = (rise | wrap) & ~play_q;
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      rep_q <= '0;
      repeat_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q <= rep_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_on = repeat_q;
`else
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (rise) state_d = HELD;
      HELD: if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    play_d = rise & ~play_q;
  end

  assign repeat_on = 1'b0;
`endif

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q <= 1'b0;
      play_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q <= pressed;
      play_q <= play_d;
    end
  end

  assign play = play_q;

endmodule

// File: tb/tb_play_button_ctrl.sv
// Directed bench for play_button_ctrl with a play-pulse scoreboard.
// Repeat expectations follow PLAY_BTN_REPEAT_EN.
module tb_play_button_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned LONG = 20;
  localparam int unsigned REP = 50;
`ifdef PLAY_BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk_50MHz = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic play, pressed, repeat_on;

  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  int exp_q[$];

  play_button_ctrl #(
    .DEBOUNCE_CYC  (DEB),
    .LONG_PRESS_CYC(LONG),
    .REPEAT_CYC    (REP)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .rst_n    (rst_n),
    .btn      (btn),
    .play     (play),
    .pressed  (pressed),
    .repeat_on(repeat_on)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  // Each play pulse must match the edge at the head of the queue.
  always @(negedge clk_50MHz) begin
    logic exp_p;
    exp_p = (exp_q.size() > 0) && (exp_q[0] == cyc);
    if (play || exp_p) begin
      vectors++;
      assert (play === exp_p) else begin
        errors++;
        $error("FAIL play_edge%0d obs=%b exp=%b", cyc, play, exp_p);
      end
      if (exp_p) void'(exp_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask

  task automatic go_to(input int e);
    step(e - cyc);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  initial begin
    int b;
    step(3);
    chk("rst_play", play, 1'b0);
    chk("rst_pressed", pressed, 1'b0);
    chk("rst_repeat", repeat_on, 1'b0);
    rst_n = 1'b1;
    step(3);

    b = cyc;
    btn = 1'b1;
    exp_q.push_back(b + 7);
    go_to(b + 5);
    chk("clean_pressed_e5", pressed, 1'b0);
    go_to(b + 6);
    chk("clean_pressed_e6", pressed, 1'b1);
    go_to(b + 10);
    btn = 1'b0;
    chk("clean_repeat", repeat_on, 1'b0);
    go_to(b + 15);
    chk("clean_rel_e15", pressed, 1'b1);
    go_to(b + 16);
    chk("clean_rel_e16", pressed, 1'b0);
    go_to(b + 20);

    for (int i = 0; i < 5; i++) begin
      btn = 1'b1;
      step(2);
      chk("bounce_hi", pressed, 1'b0);
      btn = 1'b0;
      step(2);
      chk("bounce_lo", pressed, 1'b0);
    end
    step(10);
    chk("bounce_pressed", pressed, 1'b0);
    chk("bounce_repeat", repeat_on, 1'b0);

    b = cyc;
    btn = 1'b1;
    exp_q.push_back(b + 7);
    if (REP_EN) exp_q.push_back(b + 76);
    exp_q.push_back(b + 126);
    if (REP_EN) exp_q.push_back(b + 176);
    exp_q.push_back(b + 187);
    go_to(b + 25);
    chk("long_repeat_e25", repeat_on, 1'b0);
    go_to(b + 26);
    chk("long_repeat_e26", repeat_on, REP_EN);
    go_to(b + 40);
    btn = 1'b0;
    go_to(b + 119);
    btn = 1'b1;
    go_to(b + 129);
    btn = 1'b0;
    chk("collide_repeat", repeat_on, REP_EN);
    go_to(b + 180);
    btn = 1'b1;
    go_to(b + 205);
    chk("off_repeat_e205", repeat_on, REP_EN);
    go_to(b + 206);
    chk("off_repeat_e206", repeat_on, 1'b0);
    go_to(b + 220);
    btn = 1'b0;
    go_to(b + 420);
    chk("off_repeat_end", repeat_on, 1'b0);

    b = cyc;
    btn = 1'b1;
    go_to(b + 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_play", play, 1'b0);
    chk("mid_rst_pressed", pressed, 1'b0);
    chk("mid_rst_repeat", repeat_on, 1'b0);
    go_to(b + 7);
    chk("mid_rst_pressed_e7", pressed, 1'b0);
    go_to(b + 10);
    rst_n = 1'b1;
    exp_q.push_back(b + 17);
    go_to(b + 15);
    chk("post_rst_e15", pressed, 1'b0);
    go_to(b + 16);
    chk("post_rst_e16", pressed, 1'b1);
    go_to(b + 20);
    btn = 1'b0;
    go_to(b + 40);
    chk("post_rst_repeat", repeat_on, 1'b0);

    chk("queue_drained", exp_q.size() == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/play_button_ctrl.md
PLAY_BUTTON_CTRL -- requirements
Module: play_button_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 1_000_000 (20 ms at 50 MHz), meaning the number of consecutive stable synchronized samples that accepts a new button level.
REQ-002 SHALL have parameter LONG_PRESS_CYC, default 50_000_000 (1 s), meaning the debounced hold time that toggles repeat mode.
REQ-003 SHALL have parameter REPEAT_CYC, default 400_000_000 (8 s), meaning the auto-replay period in repeat mode.
REQ-004 SHALL have port clk_50MHz, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port btn, input, 1 bit: raw, asynchronous, bouncing push-button, active-high.
REQ-007 SHALL have port play, output, 1 bit: one-cycle start pulse to the song player's play input.
REQ-008 SHALL have port pressed, output, 1 bit: debounced button level.
REQ-009 SHALL have port repeat_on, output, 1 bit: repeat mode active, for the LED.

Function
REQ-010 SHALL pass btn through a 2-flop synchronizer before any other use.
REQ-011 SHALL compare the synchronized level with pressed each cycle; while they differ a 32-bit debounce counter increments, and any equal sample clears it to 0.
REQ-012 SHALL update pressed to the synchronized level, and clear the counter, in the cycle the counter reaches DEBOUNCE_CYC-1.
REQ-013 SHALL drive play high for exactly one cycle, on the cycle after pressed rises 0->1; for a clean btn rise held high, that is DEBOUNCE_CYC+3 rising edges after btn rises.
REQ-014 SHALL ignore any bounce shorter than DEBOUNCE_CYC samples on either edge: no change on pressed and no play pulse.
REQ-015 SHALL run the FSM over states IDLE, HELD, LONG_DONE:
- IDLE -> HELD on a pressed rise.
- HELD -> LONG_DONE when the hold counter reaches LONG_PRESS_CYC-1, toggling repeat_on.
- HELD or LONG_DONE -> IDLE on a pressed fall.
REQ-016 SHALL clear the 32-bit hold counter on entry to HELD and SHALL NOT toggle repeat_on more than once per press.
REQ-017 SHALL run a 32-bit repeat counter while repeat_on=1; it wraps at REPEAT_CYC-1 and issues one play pulse on each wrap.
REQ-018 SHALL clear the repeat counter to 0 when repeat_on rises and on every press-generated play pulse.
REQ-019 SHALL hold the repeat counter at 0 while repeat_on=0.
REQ-020 SHALL issue exactly one play pulse when a press-generated pulse and a repeat wrap fall in the same cycle, with the counter restarting from 0.
REQ-021 SHALL emit its normal press play pulse on a long press that turns repeat off, and no further repeat pulses after that.
REQ-022 SHALL never hold play high for two consecutive cycles.

Reset
REQ-023 SHALL, while rst_n=0, clear the synchronizer flops, all counters, play, pressed and repeat_on to 0, and set the FSM to IDLE.
REQ-024 SHALL, on reset release with btn held high, treat the button as a fresh press, with play per REQ-013 timing.
REQ-025 SHALL abort a reset asserted mid-press or mid-repeat immediately, with no pulse emitted during reset.

Configuration
REQ-026 SHALL use macro PLAY_BTN_REPEAT_EN to compile the repeat feature in or out.
- Defined: REQ-015..REQ-021 apply.
- Undefined: no hold or repeat counters exist, repeat_on is tied to 0, the FSM reduces to IDLE/HELD, and play comes only from presses.

Structure
REQ-027 SHALL take from shared package play_btn_pkg:
- the FSM state enum;
- default cycle constants: 50 MHz, 20 ms, 1 s, 8 s;
- counter width 32.
REQ-028 SHALL implement REQ-010..REQ-012 in sub-module btn_debounce (sync plus debounce, output pressed), instantiated once.

Verification
REQ-029 SHALL run the bench with DEBOUNCE_CYC=4, LONG_PRESS_CYC=20, REPEAT_CYC=50.
REQ-030 Clean press: btn high for 10 cycles -> play=1 exactly at edge 7, pressed=1 from edge 6, repeat_on stays 0.
REQ-031 Bounce: btn toggles every 2 cycles for 20 cycles, then low -> play, pressed and repeat_on all stay 0.
REQ-032 Long press: btn high for 40 cycles -> one play at edge 7, repeat_on=1 at edge 26, then play pulses every 50 cycles; a second 40-cycle press -> one play, repeat_on=0, no further pulses.
REQ-033 Collision: in repeat mode, press timed so its play coincides with the wrap -> single one-cycle pulse, next pulse 50 cycles later.
REQ-034 Reset: rst_n low at cycle 3 of a press, released at cycle 10 with btn high -> all outputs 0 during reset, play exactly 7 edges after release.
REQ-035 Macro off: 40-cycle press -> one play, repeat_on=0, no repeat pulses over 200 cycles.
